// File: rtl/sram_write_checker_if.sv
// sram_write_checker_if
//   Snooped SRAM write bus plus the golden-data read port used by the
//   write checker.
//   Signals:
//     SRAM_we_n        write enable, active low (snooped)
//     SRAM_address     word address of the write (snooped)
//     SRAM_write_data  data being written (snooped)
//     Exp_address      golden-data read address (driven by the checker)
//     Exp_data         golden data, valid one cycle after Exp_address
//   Modports:
//     master : the bus/golden-store side that drives the write and golden data
//     slave  : the checker, which only observes the bus and drives Exp_address
interface sram_write_checker_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              SRAM_we_n;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_write_data;
    logic [ADDR_W-1:0] Exp_address;
    logic [DATA_W-1:0] Exp_data;

    modport master (
        output SRAM_we_n,
        output SRAM_address,
        output SRAM_write_data,
        output Exp_data,
        input  Exp_address
    );

    modport slave (
        input  SRAM_we_n,
        input  SRAM_address,
        input  SRAM_write_data,
        input  Exp_data,
        output Exp_address
    );
endinterface

// File: rtl/sram_write_checker.sv
// sram_write_checker
//   Hardware scoreboard on the SRAM write bus. It compares each write against
//   golden data, flags writes outside [REGION_LO, REGION_HI], detects repeated
//   writes through a written-bitmap, and after Finish sweeps the bitmap to
//   count locations never written.
//   Ports:
//     Clock_50, Reset        clock (rising edge) and async active-high reset
//     Start                  pulse: zero results, clear bitmap, then monitor
//     Finish                 pulse (MONITOR only): drain, sweep, then DONE
//     bus                    snooped write bus + golden read port (slave)
//     *_count                saturating error counters
//     Busy / Done / Pass     status (Busy in CLEAR and SWEEP)
//     Err_limit / Overrun    sticky flags
//     First_err_*            first mismatch capture
//   Optional feature macro: CHECKER_FIRST_ERR_EN enables the First_err_*
//   capture registers; without it those outputs are tied to zero.
module sram_write_checker #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int REGION_LO = 146944,
    parameter int REGION_HI = 262143,
    parameter int CNT_W     = 20,
    parameter int MAX_ERR   = 30
) (
    input  logic                  Clock_50,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Finish,
    sram_write_checker_if.slave   bus,
    output logic [CNT_W-1:0]      Mismatch_count,
    output logic [CNT_W-1:0]      Region_count,
    output logic [CNT_W-1:0]      Multi_count,
    output logic [CNT_W-1:0]      Unwritten_count,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Pass,
    output logic                  Err_limit,
    output logic                  Overrun,
    output logic [ADDR_W-1:0]     First_err_address,
    output logic [DATA_W-1:0]     First_err_data,
    output logic [DATA_W-1:0]     First_err_exp
);
    localparam int DEPTH = REGION_HI - REGION_LO + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  END_PTR   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [ADDR_W:0]   LO_X      = (ADDR_W+1)'(REGION_LO);
    localparam logic [ADDR_W:0]   HI_X      = (ADDR_W+1)'(REGION_HI);
    localparam logic [ADDR_W-1:0] LO_A      = ADDR_W'(REGION_LO);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  MAX_ERR_C = CNT_W'(MAX_ERR);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        MONITOR = 3'd2,
        DRAIN   = 3'd3,
        SWEEP   = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        if (en && (c != CNT_MAX)) return c + CNT_W'(1);
        else                      return c;
    endfunction

    // Compared one bit wider so a region ending at the top of the address
    // space does not turn into a constant comparison.
    function automatic logic in_region(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= LO_X) && ({1'b0, a} <= HI_X);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a - LO_A);
    endfunction

    state_t            state_r;
    logic [PTR_W-1:0]  ptr_r;
    logic              s1_valid_r;
    logic              s1_inreg_r;
    logic              fwd_r;
    logic [ADDR_W-1:0] s1_addr_r;
    logic [DATA_W-1:0] s1_data_r;
    logic [ADDR_W-1:0] exp_hold_r;
    logic              sw_vld_r;
    logic              bm_rd_r;
    logic              bitmap_r [0:DEPTH-1];

    logic              we_evt_s, wr_inreg_s;
    logic              s1_mis_s, s1_oor_s, s1_multi_s, sw_zero_s;
    logic [CNT_W-1:0]  mis_nxt_s, reg_nxt_s, mul_nxt_s, unw_nxt_s;
    logic              ovr_nxt_s, pass_nxt_s;
    logic              bm_we_s, bm_wdata_s, bm_re_s;
    logic [IDX_W-1:0]  bm_widx_s, bm_ridx_s;

    assign we_evt_s   = (state_r == MONITOR) && !bus.SRAM_we_n;
    assign wr_inreg_s = in_region(bus.SRAM_address);
    assign s1_mis_s   = s1_valid_r && (bus.Exp_data != s1_data_r);
    assign s1_oor_s   = s1_valid_r && !s1_inreg_r;
    // fwd_r covers the back-to-back case where the bitmap read races the
    // stage-1 write of the same bit.
    assign s1_multi_s = s1_valid_r && s1_inreg_r && (bm_rd_r || fwd_r);
    assign sw_zero_s  = sw_vld_r && !bm_rd_r;

    assign mis_nxt_s  = sat_inc(Mismatch_count, s1_mis_s);
    assign reg_nxt_s  = sat_inc(Region_count, s1_oor_s);
    assign mul_nxt_s  = sat_inc(Multi_count, s1_multi_s);
    assign unw_nxt_s  = sat_inc(Unwritten_count, sw_zero_s);
    assign ovr_nxt_s  = Overrun || (!bus.SRAM_we_n && ((state_r == CLEAR) || (state_r == SWEEP)));
    // Pass is taken from next-state values so the final sweep count lands in it.
    assign pass_nxt_s = (mis_nxt_s == CNT_ZERO) && (reg_nxt_s == CNT_ZERO) &&
                        (mul_nxt_s == CNT_ZERO) && (unw_nxt_s == CNT_ZERO) && !ovr_nxt_s;

    // Golden store is addressed straight from the bus during a write so its
    // data arrives while the write sits in stage 1; otherwise the last address holds.
    assign bus.Exp_address = we_evt_s ? bus.SRAM_address : exp_hold_r;

    // Bitmap port selection: one write port and one registered read port per state.
    always_comb begin
        bm_we_s    = 1'b0;
        bm_wdata_s = 1'b0;
        bm_widx_s  = {IDX_W{1'b0}};
        bm_re_s    = 1'b0;
        bm_ridx_s  = {IDX_W{1'b0}};
        case (state_r)
            CLEAR: begin
                bm_we_s   = 1'b1;
                bm_widx_s = IDX_W'(ptr_r);
            end
            MONITOR, DRAIN: begin
                bm_we_s    = s1_valid_r && s1_inreg_r;
                bm_wdata_s = 1'b1;
                bm_widx_s  = to_idx(s1_addr_r);
                bm_re_s    = we_evt_s && wr_inreg_s;
                bm_ridx_s  = to_idx(bus.SRAM_address);
            end
            SWEEP: begin
                bm_re_s   = (ptr_r != END_PTR);
                bm_ridx_s = IDX_W'(ptr_r);
            end
            default: begin
                bm_we_s = 1'b0;
                bm_re_s = 1'b0;
            end
        endcase
    end

    // Written-bitmap storage; no reset so it can map onto block RAM.
    always_ff @(posedge Clock_50) begin
        if (bm_we_s) bitmap_r[bm_widx_s] <= bm_wdata_s;
        if (bm_re_s) bm_rd_r <= bitmap_r[bm_ridx_s];
    end

    // Control FSM, write pipeline, counters and status flags.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_r         <= IDLE;
            ptr_r           <= PTR_ZERO;
            s1_valid_r      <= 1'b0;
            s1_inreg_r      <= 1'b0;
            fwd_r           <= 1'b0;
            s1_addr_r       <= {ADDR_W{1'b0}};
            s1_data_r       <= {DATA_W{1'b0}};
            exp_hold_r      <= {ADDR_W{1'b0}};
            sw_vld_r        <= 1'b0;
            Mismatch_count  <= CNT_ZERO;
            Region_count    <= CNT_ZERO;
            Multi_count     <= CNT_ZERO;
            Unwritten_count <= CNT_ZERO;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            Pass            <= 1'b0;
            Err_limit       <= 1'b0;
            Overrun         <= 1'b0;
        end else if (Start) begin
            state_r         <= CLEAR;
            ptr_r           <= PTR_ZERO;
            s1_valid_r      <= 1'b0;
            fwd_r           <= 1'b0;
            sw_vld_r        <= 1'b0;
            Mismatch_count  <= CNT_ZERO;
            Region_count    <= CNT_ZERO;
            Multi_count     <= CNT_ZERO;
            Unwritten_count <= CNT_ZERO;
            Busy            <= 1'b1;
            Done            <= 1'b0;
            Pass            <= 1'b0;
            Err_limit       <= 1'b0;
            Overrun         <= 1'b0;
        end else begin
            s1_valid_r <= we_evt_s;
            if (we_evt_s) begin
                s1_addr_r  <= bus.SRAM_address;
                s1_data_r  <= bus.SRAM_write_data;
                s1_inreg_r <= wr_inreg_s;
                exp_hold_r <= bus.SRAM_address;
                fwd_r      <= s1_valid_r && s1_inreg_r && (s1_addr_r == bus.SRAM_address);
            end
            sw_vld_r        <= (state_r == SWEEP) && (ptr_r != END_PTR);
            Mismatch_count  <= mis_nxt_s;
            Region_count    <= reg_nxt_s;
            Multi_count     <= mul_nxt_s;
            Unwritten_count <= unw_nxt_s;
            Err_limit       <= Err_limit || (mis_nxt_s >= MAX_ERR_C);
            Overrun         <= ovr_nxt_s;
            case (state_r)
                IDLE: state_r <= IDLE;
                CLEAR: begin
                    if (ptr_r == LAST_PTR) begin
                        state_r <= MONITOR;
                        ptr_r   <= PTR_ZERO;
                        Busy    <= 1'b0;
                    end else begin
                        ptr_r <= ptr_r + PTR_W'(1);
                    end
                end
                MONITOR: begin
                    if (Finish) state_r <= DRAIN;
                end
                DRAIN: begin
                    state_r <= SWEEP;
                    ptr_r   <= PTR_ZERO;
                    Busy    <= 1'b1;
                end
                SWEEP: begin
                    // One extra cycle after the last read retires its result.
                    if (ptr_r == END_PTR) begin
                        state_r <= DONE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Pass    <= pass_nxt_s;
                    end else begin
                        ptr_r <= ptr_r + PTR_W'(1);
                    end
                end
                DONE: state_r <= DONE;
                default: begin
                    state_r <= IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    Pass    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHECKER_FIRST_ERR_EN
    logic fe_taken_r;

    // First mismatch capture, frozen until the next Start.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            fe_taken_r        <= 1'b0;
            First_err_address <= {ADDR_W{1'b0}};
            First_err_data    <= {DATA_W{1'b0}};
            First_err_exp     <= {DATA_W{1'b0}};
        end else if (Start) begin
            fe_taken_r        <= 1'b0;
            First_err_address <= {ADDR_W{1'b0}};
            First_err_data    <= {DATA_W{1'b0}};
            First_err_exp     <= {DATA_W{1'b0}};
        end else if (s1_mis_s && !fe_taken_r) begin
            fe_taken_r        <= 1'b1;
            First_err_address <= s1_addr_r;
            First_err_data    <= s1_data_r;
            First_err_exp     <= bus.Exp_data;
        end
    end
`else
    assign First_err_address = {ADDR_W{1'b0}};
    assign First_err_data    = {DATA_W{1'b0}};
    assign First_err_exp     = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_sram_write_checker.sv
// Testbench for sram_write_checker: table of writes with expected counter
// effects, a scoreboard queue checked two cycles after each write, and
// hand-written sequences for clear/sweep timing, overrun and reset.
module tb_sram_write_checker;
    localparam int ADDR_W = 4, DATA_W = 16, REGION_LO = 8, REGION_HI = 15;
    localparam int CNT_W = 4, MAX_ERR = 3, CNT_SAT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, finish;
    logic [CNT_W-1:0]  Mismatch_count, Region_count, Multi_count, Unwritten_count;
    logic              Busy, Done, Pass, Err_limit, Overrun;
    logic [ADDR_W-1:0] First_err_address;
    logic [DATA_W-1:0] First_err_data, First_err_exp;

    sram_write_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_write_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REGION_LO(REGION_LO), .REGION_HI(REGION_HI),
        .CNT_W(CNT_W), .MAX_ERR(MAX_ERR)
    ) dut (
        .Clock_50(clk), .Reset(rst), .Start(start), .Finish(finish), .bus(bus),
        .Mismatch_count(Mismatch_count), .Region_count(Region_count),
        .Multi_count(Multi_count), .Unwritten_count(Unwritten_count),
        .Busy(Busy), .Done(Done), .Pass(Pass), .Err_limit(Err_limit), .Overrun(Overrun),
        .First_err_address(First_err_address), .First_err_data(First_err_data),
        .First_err_exp(First_err_exp)
    );

    // Golden store: synchronous read, data = address * 0x11.
    always @(posedge clk) bus.Exp_data <= 16'(bus.Exp_address) * 16'h0011;

    typedef struct {
        int          seg;
        logic [3:0]  addr;
        logic [15:0] data;
        bit          gap;
        bit          mis;
        bit          oor;
        bit          multi;
    } vec_t;

    typedef struct {
        int due;
        int mis;
        int oor;
        int multi;
        bit err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   e_mis, e_oor, e_multi;
    bit   e_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void add(int seg, int a, int d, bit gap, bit mis, bit oor, bit multi);
        vec_t v;
        v.seg = seg; v.addr = 4'(a); v.data = 16'(d); v.gap = gap;
        v.mis = mis; v.oor = oor; v.multi = multi;
        vecs.push_back(v);
    endfunction

    function automatic int sat(int v);
        return (v > CNT_SAT) ? CNT_SAT : v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard checker: counters are due two edges after the write cycle.
    always @(negedge clk) begin
        exp_t got;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            got = sb.pop_front();
            chk("sb_latency", 32'(cyc), 32'(got.due));
            chk("mismatch_count", 32'(Mismatch_count), 32'(got.mis));
            chk("region_count", 32'(Region_count), 32'(got.oor));
            chk("multi_count", 32'(Multi_count), 32'(got.multi));
            chk("err_limit", 32'(Err_limit), 32'(got.err));
        end
    end

    task automatic model_clear;
        e_mis = 0; e_oor = 0; e_multi = 0; e_err = 1'b0;
    endtask

    task automatic do_start;
        int n;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_clear();
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!Busy) break;
            n++;
        end
        chk("clear_cycles", 32'(n), 32'd8);
        tick;
    endtask

    task automatic apply_seg(input int seg);
        exp_t e;
        foreach (vecs[i]) begin
            if (vecs[i].seg == seg) begin
                if (vecs[i].gap) tick;
                bus.SRAM_we_n       = 1'b0;
                bus.SRAM_address    = vecs[i].addr;
                bus.SRAM_write_data = vecs[i].data;
                e_mis   = sat(e_mis + int'(vecs[i].mis));
                e_oor   = sat(e_oor + int'(vecs[i].oor));
                e_multi = sat(e_multi + int'(vecs[i].multi));
                e_err   = e_err || (e_mis >= MAX_ERR);
                e.due = cyc + 2; e.mis = e_mis; e.oor = e_oor; e.multi = e_multi; e.err = e_err;
                sb.push_back(e);
                tick;
                bus.SRAM_we_n = 1'b1;
            end
        end
        repeat (3) tick;
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_finish(input int exp_unw, input bit exp_pass);
        int n, w;
        finish = 1'b1;
        tick;
        finish = 1'b0;
        n = 0; w = 0;
        @(negedge clk);
        while (!Busy && w < 16) begin
            @(negedge clk);
            w++;
        end
        while (Busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("sweep_cycles", 32'(n), 32'd9);
        chk("done", 32'(Done), 32'd1);
        chk("pass", 32'(Pass), 32'(exp_pass));
        chk("unwritten_count", 32'(Unwritten_count), 32'(exp_unw));
        repeat (3) @(negedge clk);
        chk("done_stable", 32'(Done), 32'd1);
        chk("pass_stable", 32'(Pass), 32'(exp_pass));
        tick;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mismatch"}, 32'(Mismatch_count), 32'd0);
        chk({tag, "_region"}, 32'(Region_count), 32'd0);
        chk({tag, "_multi"}, 32'(Multi_count), 32'd0);
        chk({tag, "_unwritten"}, 32'(Unwritten_count), 32'd0);
        chk({tag, "_flags"}, 32'({Busy, Done, Pass, Err_limit, Overrun}), 32'd0);
        chk({tag, "_exp_addr"}, 32'(bus.Exp_address), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0;
        bus.SRAM_we_n = 1'b1; bus.SRAM_address = 4'd0; bus.SRAM_write_data = 16'd0;
        model_clear();

        // seg1: full region correct, back-to-back
        for (int a = 8; a <= 15; a++) add(1, a, a * 17, 1'b0, 1'b0, 1'b0, 1'b0);
        // seg2: two mismatches; the first must stay captured
        add(2, 9, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2, 10, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        // seg3: out-of-region, then forwarded duplicate, then rest of region
        add(3, 3, 16'h0033, 1'b0, 1'b0, 1'b1, 1'b0);
        add(3, 10, 16'h00AA, 1'b1, 1'b0, 1'b0, 1'b0);
        add(3, 10, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int a = 8; a <= 15; a++) if (a != 10) add(3, a, a * 17, 1'b0, 1'b0, 1'b0, 1'b0);
        // seg4: partial region, duplicate one idle cycle later via the bitmap
        for (int a = 8; a <= 12; a++) add(4, a, a * 17, 1'b0, 1'b0, 1'b0, 1'b0);
        add(4, 12, 16'h00CC, 1'b1, 1'b0, 1'b0, 1'b1);
        // seg5: 20 mismatches, saturation and error limit
        for (int i = 0; i < 20; i++) add(5, 8 + (i % 8), 16'hFFFF, 1'b0, 1'b1, 1'b0, (i >= 8));
        // seg6: first real write after an overrun write in CLEAR
        add(6, 9, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        chk("reset_fe_addr", 32'(First_err_address), 32'd0);
        chk("reset_fe_data", 32'(First_err_data), 32'd0);
        chk("reset_fe_exp", 32'(First_err_exp), 32'd0);

        // Finish outside MONITOR is ignored
        tick;
        finish = 1'b1;
        tick;
        finish = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("finish_in_idle_done", 32'({Busy, Done}), 32'd0);
        tick;

        do_start();
        apply_seg(1);
        do_finish(0, 1'b1);

        do_start();
        apply_seg(2);
`ifdef CHECKER_FIRST_ERR_EN
        chk("first_err_address", 32'(First_err_address), 32'd9);
        chk("first_err_data", 32'(First_err_data), 32'h0000);
        chk("first_err_exp", 32'(First_err_exp), 32'h0099);
`else
        chk("first_err_address", 32'(First_err_address), 32'd0);
        chk("first_err_data", 32'(First_err_data), 32'd0);
        chk("first_err_exp", 32'(First_err_exp), 32'd0);
`endif
        do_finish(6, 1'b0);

        do_start();
        apply_seg(3);
        do_finish(0, 1'b0);
        chk("seg3_region_final", 32'(Region_count), 32'd1);
        chk("seg3_multi_final", 32'(Multi_count), 32'd1);

        do_start();
        apply_seg(4);
        do_finish(3, 1'b0);

        do_start();
        apply_seg(5);
        chk("seg5_mismatch_sat", 32'(Mismatch_count), 32'd15);
        chk("seg5_err_limit", 32'(Err_limit), 32'd1);

        // seg6: write during CLEAR sets Overrun and is not checked
        start = 1'b1;
        tick;
        start = 1'b0;
        bus.SRAM_we_n = 1'b0; bus.SRAM_address = 4'd9; bus.SRAM_write_data = 16'h0000;
        tick;
        bus.SRAM_we_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!Busy) break;
        end
        @(negedge clk);
        chk("overrun_set", 32'(Overrun), 32'd1);
        chk("overrun_not_counted", 32'(Mismatch_count), 32'd0);
        model_clear();
        tick;
        apply_seg(6);

        // Exp_address follows a write and then holds
        bus.SRAM_we_n = 1'b0; bus.SRAM_address = 4'd11; bus.SRAM_write_data = 16'h00BB;
        @(negedge clk);
        chk("exp_addr_follow", 32'(bus.Exp_address), 32'd11);
        tick;
        bus.SRAM_we_n = 1'b1; bus.SRAM_address = 4'd2;
        @(negedge clk);
        chk("exp_addr_hold", 32'(bus.Exp_address), 32'd11);
        tick;

        // Reset with a mismatching write in flight
        bus.SRAM_we_n = 1'b0; bus.SRAM_address = 4'd13; bus.SRAM_write_data = 16'h0000;
        tick;
        bus.SRAM_we_n = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        // Back in IDLE: a write is neither checked nor looked up
        bus.SRAM_we_n = 1'b0; bus.SRAM_address = 4'd14; bus.SRAM_write_data = 16'h0000;
        @(negedge clk);
        chk("idle_exp_addr", 32'(bus.Exp_address), 32'd0);
        tick;
        bus.SRAM_we_n = 1'b1;
        repeat (3) tick;
        @(negedge clk);
        chk_all_zero("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_write_checker.md
# sram_write_checker

Synthesisable, parametrised SRAM write scoreboard that sits on the SRAM write bus between the decoder milestones and the SRAM controller. It moves the checks our simulation bench does today into hardware, so they can run on the board as well:
- expected-data compare against a golden-data port;
- out-of-region detection;
- duplicate-write detection through an internal written-bitmap;
- a post-run sweep counting unwritten locations in the target region.

Results appear on counters and sticky flags readable by the top level (seven-segment and LEDs).

## Interface
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- REGION_LO, 146944, first address of the writable region.
- REGION_HI, 262143, last address of the writable region; REGION_LO ≤ REGION_HI < 2^ADDR_W.
- CNT_W, 20, width of every error counter.
- MAX_ERR, 30, mismatch count at which Err_limit asserts.

- Clock_50  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse: clear state, start bitmap clear.
- Finish  in  1  one-cycle pulse: end monitoring, start unwritten sweep.
- SRAM_we_n  in  1  snooped write enable, active low.
- SRAM_address  in  ADDR_W  snooped address.
- SRAM_write_data  in  DATA_W  snooped write data.
- Exp_address  out  ADDR_W  golden-data read address.
- Exp_data  in  DATA_W  golden data, valid exactly 1 cycle after Exp_address.
- Mismatch_count, Region_count, Multi_count, Unwritten_count  out  CNT_W each  saturating error counters.
- Busy  out  1  high in CLEAR and SWEEP.
- Done  out  1  high in DONE.
- Pass  out  1  Done and all four counters zero and Overrun low.
- Err_limit  out  1  sticky; set when Mismatch_count reaches MAX_ERR.
- Overrun  out  1  sticky; set if a write is seen in CLEAR or SWEEP.
- First_err_address  out  ADDR_W  address of first mismatch.
- First_err_data  out  DATA_W  data written at first mismatch.
- First_err_exp  out  DATA_W  expected data at first mismatch.

## Operation
- States: IDLE → (Start) CLEAR → (last region address cleared) MONITOR → (Finish) DRAIN → (pipeline empty) SWEEP → (REGION_HI read and counted) DONE → (Start) CLEAR.
- Start is honoured in any state and restarts CLEAR. Finish is ignored outside MONITOR.
- **CLEAR:**
  - Writes 0 to bitmap[REGION_LO..REGION_HI], one location per cycle.
  - Counters, sticky flags and first-error registers are zeroed on Start.
- **MONITOR, stage 0:** on a cycle with SRAM_we_n == 0:
  - capture address and data;
  - drive Exp_address = SRAM_address;
  - read bitmap[address] if the address is in region.
- **MONITOR, stage 1:**
  - Exp_data ≠ captured data → Mismatch_count++.
  - Address outside [REGION_LO, REGION_HI] → Region_count++; the bitmap is neither read nor written, but data is still compared.
  - In-region and bitmap bit (or forwarded bit) already 1 → Multi_count++.
  - In-region: write 1 to the bitmap bit.
  - A single write may increment several counters in the same cycle.
- **Forwarding:** the stage-1 address equals the stage-0 address on back-to-back writes. Stage 0 then treats the bit as 1 regardless of the bitmap read.
- **DRAIN:** exactly one cycle, retiring stage 1.
- **SWEEP:**
  - Reads bitmap from REGION_LO to REGION_HI, one per cycle.
  - 1-cycle read latency; each 0 read increments Unwritten_count.
- Writes seen in CLEAR, SWEEP, IDLE or DONE are not checked. In CLEAR and SWEEP they also set Overrun.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Exp_address holds its last value when there is no write event.

## Timing
- Reset values: all counters 0; Busy, Done, Pass, Err_limit, Overrun 0; Exp_address 0; First_err_* 0; state IDLE. The bitmap content is undefined after reset.
- Reset mid-operation returns to IDLE immediately. Start is required before checking resumes.
- Write-to-counter latency: 2 cycles (event at cycle n, counter updated after edge n+1).
- One write per cycle is sustained with no stalls.
- CLEAR lasts REGION_HI−REGION_LO+1 cycles.
- SWEEP lasts REGION_HI−REGION_LO+2 cycles.
- Err_limit asserts in the same cycle Mismatch_count becomes MAX_ERR.
- Done and Pass are registered and remain stable until Start or Reset.

## Configuration
- CHECKER_FIRST_ERR_EN defined:
  - First_err_* registers capture stage-1 address, data and Exp_data on the first mismatch after Start.
  - They are frozen afterwards.
- Not defined:
  - First_err_* are constant 0.
  - No capture registers are synthesised.
  - All other behaviour is identical.

## Test plan
Bench parameters: ADDR_W=4, REGION_LO=8, REGION_HI=15, CNT_W=4, MAX_ERR=3. The golden model returns Exp_data = address×0x11.
- Start; write addr 8..15 with correct data, back-to-back; Finish → Done, Pass=1, all counters 0.
- Write addr 9 with 0x0000 (expected 0x99); CHECKER_FIRST_ERR_EN defined → Mismatch_count=1, First_err_address=9, First_err_data=0x0000, First_err_exp=0x99.
- Write addr 3 correct, then addr 10 twice on consecutive cycles → Region_count=1, Multi_count=1 (forwarding path); after Finish with 8..15 otherwise written, Unwritten_count=0.
- Write only addr 8..12; Finish → Unwritten_count=3, Pass=0, SWEEP Busy high for exactly 9 cycles.
- 20 mismatching writes → Err_limit set at the 3rd; Mismatch_count saturates at 15.
- Write during CLEAR → Overrun=1 and the write is not counted; Reset asserted during MONITOR → all outputs 0 and state IDLE on the next edge.
